// File: rtl/tx_frame_buffer.sv
// tx_frame_buffer
// Queues up to NUM_SEQ sorted arrays and sends each one to uart_tx as a
// framed byte stream: HEADER, LEN, payload (word 0 first, byte order chosen
// by MSB_FIRST) and, when TX_FRAME_CHECKSUM_EN is defined, a trailing byte
// holding the sum of the payload bytes modulo 256.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   valid_in     array_in is valid this cycle
//   array_in     DEPTH words of WIDTH bits
//   full         FIFO holds NUM_SEQ arrays (registered)
//   count        arrays stored, including the one being sent (registered)
//   tx_busy      busy from uart_tx
//   byte_out     data byte to uart_tx, held from one issue to the next
//   valid_out    start pulse to uart_tx
//   frame_done   pulse when the last byte of a frame has left the UART
//   overflow     pulse the cycle after a write arrived while full
//
// Optional feature macro: TX_FRAME_CHECKSUM_EN
module tx_frame_buffer #(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 8,
  parameter int          NUM_SEQ   = 4,
  parameter int          MSB_FIRST = 1,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             valid_in,
  input  logic [WIDTH-1:0]                 array_in [DEPTH-1:0],
  output logic                             full,
  output logic [$clog2(NUM_SEQ+1)-1:0]     count,
  input  logic                             tx_busy,
  output logic [7:0]                       byte_out,
  output logic                             valid_out,
  output logic                             frame_done,
  output logic                             overflow
);

  localparam int BPW   = WIDTH / 8;
  localparam int LEN   = DEPTH * BPW;
`ifdef TX_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = LEN + 3;
`else
  localparam int FRAME_LEN = LEN + 2;
`endif
  localparam int CNT_W = $clog2(NUM_SEQ + 1);
  localparam int PTR_W = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
  localparam int IDX_W = $clog2(LEN + 3);
  localparam int WRD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUB_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mem [NUM_SEQ][DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count_nxt;
  logic [IDX_W-1:0]     byte_idx;   // frame position of the byte in byte_out
  logic [WRD_W-1:0]     word_idx;   // word holding the next payload byte
  logic [SUB_W-1:0]     sub_idx;    // byte slot within that word
  logic                 wr_en, pop, last_byte;
  logic                 load_first, load_next;
  logic                 nxt_is_len, nxt_is_payload;
  logic [WIDTH-1:0]     cur_word;
  logic [7:0]           pl_byte, next_byte;

  assign wr_en     = valid_in && !full;
  assign pop       = frame_done;
  assign last_byte = (byte_idx == IDX_W'(FRAME_LEN - 1));

  // NOTE: storage carries no reset; its contents are only read after a write
  // has filled the slot, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int d = 0; d < DEPTH; d++) mem[wr_ptr][d] <= array_in[d];
    end
  end

  always_comb begin
    count_nxt = count;
    if (wr_en && !pop)      count_nxt = count + 1'b1;
    else if (!wr_en && pop) count_nxt = count - 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(NUM_SEQ - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= (rd_ptr == PTR_W'(NUM_SEQ - 1)) ? '0 : rd_ptr + 1'b1;
      count    <= count_nxt;
      full     <= (count_nxt == CNT_W'(NUM_SEQ));
      // A write while full is dropped even if a pop frees a slot this cycle.
      overflow <= valid_in && full;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    valid_out  = 1'b0;
    frame_done = 1'b0;
    load_first = 1'b0;
    load_next  = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        load_first = 1'b1;
        state_nxt  = ISSUE;
      end
      ISSUE: if (!tx_busy) begin
        valid_out = 1'b1;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: if (tx_busy) state_nxt = WAIT_LO;
      WAIT_LO: if (!tx_busy) begin
        if (last_byte) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end else begin
          load_next = 1'b1;
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte that follows the one currently in byte_out.
  always_comb begin
    cur_word = mem[rd_ptr][word_idx];
    pl_byte  = '0;
    for (int b = 0; b < BPW; b++) begin
      if (sub_idx == SUB_W'(b))
        pl_byte = cur_word[((MSB_FIRST != 0) ? (BPW - 1 - b) : b) * 8 +: 8];
    end
  end

  assign nxt_is_len     = (byte_idx == '0);
  assign nxt_is_payload = !nxt_is_len && (byte_idx < IDX_W'(LEN + 1));

`ifdef TX_FRAME_CHECKSUM_EN
  logic [7:0] csum;
  assign next_byte = nxt_is_len ? 8'(LEN) : (nxt_is_payload ? pl_byte : csum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        csum <= '0;
    else if (load_first)               csum <= '0;
    else if (load_next && nxt_is_payload) csum <= csum + pl_byte;
  end
`else
  assign next_byte = nxt_is_len ? 8'(LEN) : pl_byte;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_out <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      sub_idx  <= '0;
    end else if (load_first) begin
      byte_out <= HEADER;
      byte_idx <= '0;
      word_idx <= '0;
      sub_idx  <= '0;
    end else if (load_next) begin
      byte_out <= next_byte;
      byte_idx <= byte_idx + 1'b1;
      if (nxt_is_payload) begin
        if (sub_idx == SUB_W'(BPW - 1)) begin
          sub_idx  <= '0;
          word_idx <= word_idx + 1'b1;
        end else begin
          sub_idx <= sub_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Self-checking bench for tx_frame_buffer. A bench-side UART model answers
// each start pulse with a busy window of random delay and length. A queue of
// expected bytes, built from each accepted array, plus a frame counter give
// every byte, count, full and overflow value the DUT must show. A second,
// small instance (WIDTH=16, DEPTH=2, LSB first) is checked against literals.
module tb_tx_frame_buffer;

  localparam int W = 32, D = 8, NS = 4, BPW = W / 8, LEN = D * BPW;
`ifdef TX_FRAME_CHECKSUM_EN
  localparam int FLEN = LEN + 3;
`else
  localparam int FLEN = LEN + 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n, valid_in, tx_busy;
  logic [W-1:0] array_in [D-1:0];
  logic        full, valid_out, frame_done, overflow;
  logic [2:0]  count;
  logic [7:0]  byte_out;

  logic        valid_in2, tx_busy2;
  logic [15:0] array_in2 [1:0];
  logic        full2, valid_out2, frame_done2, overflow2;
  logic [1:0]  count2;
  logic [7:0]  byte_out2;

  int pass_cnt = 0, chk_cnt = 0;

  always #5 clk = ~clk;

  tx_frame_buffer #(.WIDTH(W), .DEPTH(D), .NUM_SEQ(NS), .MSB_FIRST(1), .HEADER(8'hA5)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .array_in(array_in), .full(full),
    .count(count), .tx_busy(tx_busy), .byte_out(byte_out), .valid_out(valid_out),
    .frame_done(frame_done), .overflow(overflow));

  tx_frame_buffer #(.WIDTH(16), .DEPTH(2), .NUM_SEQ(2), .MSB_FIRST(0), .HEADER(8'hA5)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in2), .array_in(array_in2), .full(full2),
    .count(count2), .tx_busy(tx_busy2), .byte_out(byte_out2), .valid_out(valid_out2),
    .frame_done(frame_done2), .overflow(overflow2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- reference model and compare process -------------------
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int  m_cnt = 0, m_pos = 0, fd_cnt = 0;
  bit  m_ovf = 0, force_busy = 0;

  initial begin
    bit busy_int;
    int pend, hold, sum;
    logic [7:0] b;
    bit wr, pop;
    busy_int = 0; pend = 0; hold = 0; tx_busy = 0;
    forever begin
      @(negedge clk);
      // UART stand-in: busy rises 1..3 cycles after a start, lasts 1..4 cycles.
      if (!rst_n) begin
        busy_int = 0; pend = 0; hold = 0;
      end else if (busy_int) begin
        if (hold == 0) busy_int = 0; else hold--;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin busy_int = 1; hold = $urandom_range(0, 3); end
      end
      tx_busy = busy_int || force_busy;
      #2;
      if (!rst_n) begin
        exp_q.delete(); m_cnt = 0; m_pos = 0; m_ovf = 0;
      end else begin
        check("count", count, m_cnt);
        check("full", full, m_cnt == NS);
        check("overflow", overflow, m_ovf);
        if (valid_out && tx_busy) check("valid_while_busy", 1, 0);
        if (valid_out) begin
          if (exp_q.size() == 0) check("unexpected_byte", byte_out, 8'hxx);
          else check("byte_out", byte_out, exp_q.pop_front());
          rx_log.push_back(byte_out);
          m_pos++;
          pend = $urandom_range(1, 3);
        end
        pop = frame_done;
        if (pop) begin
          check("frame_done_len", m_pos, FLEN);
          m_pos = 0;
          fd_cnt++;
        end
        wr    = valid_in && (m_cnt < NS);
        m_ovf = valid_in && (m_cnt == NS);
        if (wr) begin
          exp_q.push_back(8'hA5);
          exp_q.push_back(8'(LEN));
          sum = 0;
          for (int w = 0; w < D; w++)
            for (int k = 0; k < BPW; k++) begin
              b = 8'(array_in[w] >> (8 * (BPW - 1 - k)));
              exp_q.push_back(b);
              sum += int'(b);
            end
`ifdef TX_FRAME_CHECKSUM_EN
          exp_q.push_back(8'(sum));
`endif
        end
        m_cnt = m_cnt + int'(wr) - int'(pop);
      end
    end
  end

  // ---------------- second instance: WIDTH=16, DEPTH=2, LSB first ----------
  bit dut2_done = 0;
  initial begin
    logic [7:0] rx2[$];
`ifdef TX_FRAME_CHECKSUM_EN
    logic [7:0] lit2 [7] = '{8'hA5, 8'h04, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hBE};
`else
    logic [7:0] lit2 [6] = '{8'hA5, 8'h04, 8'h34, 8'h12, 8'hCD, 8'hAB};
`endif
    bit raise; int hold2, c;
    valid_in2 = 0; tx_busy2 = 0; array_in2[0] = '0; array_in2[1] = '0;
    raise = 0; hold2 = 0;
    wait (rst_n === 1'b1);
    @(negedge clk);
    array_in2[0] = 16'h1234; array_in2[1] = 16'hABCD; valid_in2 = 1;
    @(negedge clk);
    valid_in2 = 0;
    for (c = 0; c < 400; c++) begin
      @(negedge clk);
      if (raise) begin tx_busy2 = 1; raise = 0; hold2 = 2; end
      else if (hold2 > 0) begin hold2--; if (hold2 == 0) tx_busy2 = 0; end
      #2;
      if (valid_out2) begin rx2.push_back(byte_out2); raise = 1; end
      if (frame_done2) break;
    end
    check("dut2_timeout", c >= 400, 0);
    check("dut2_len", rx2.size(), $size(lit2));
    for (int i = 0; i < $size(lit2) && i < rx2.size(); i++) check("dut2_byte", rx2[i], lit2[i]);
    @(negedge clk); #2;
    check("dut2_count_after", count2, 0);
    dut2_done = 1;
  end

  // ---------------- stimulus -----------------------------------------------
  task automatic fill(input bit rnd);
    for (int i = 0; i < D; i++) array_in[i] = rnd ? W'($urandom) : W'(i);
  endtask

  task automatic write_one(input bit rnd);
    @(negedge clk);
    fill(rnd); valid_in = 1;
    @(negedge clk);
    valid_in = 0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 8000 && (m_cnt != 0 || exp_q.size() != 0); n++) @(negedge clk);
    check("drain_timeout", n >= 8000, 0);
    @(negedge clk); #3;
    check("count_drained", count, 0);
  endtask

  // Waits until frame_done is high in the current cycle (sampled at negedge+1).
  task automatic wait_fd(output bit timed_out);
    int n;
    timed_out = 1;
    for (n = 0; n < 4000; n++) begin
      @(negedge clk); #1;
      if (frame_done) begin timed_out = 0; break; end
    end
  endtask

  initial begin
    bit to;
    int n, sz;
    rst_n = 0; valid_in = 0; fill(0);
    #3;
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_byte_out", byte_out, 0);
    check("rst_valid_out", valid_out, 0);
    #9 rst_n = 1;

    // Test 1: array_in[i] = i, literal pins on the received stream.
    rx_log.delete(); fd_cnt = 0;
    write_one(0);
    drain();
    check("t1_len", rx_log.size(), FLEN);
    if (rx_log.size() == FLEN) begin
      check("t1_hdr", rx_log[0], 8'hA5);
      check("t1_len_byte", rx_log[1], 8'h20);
      check("t1_b5", rx_log[5], 8'h00);
      check("t1_b9", rx_log[9], 8'h01);
      check("t1_last_payload", rx_log[33], 8'h07);
`ifdef TX_FRAME_CHECKSUM_EN
      check("t1_checksum", rx_log[34], 8'h1C);
`endif
    end
    check("t1_frame_done_once", fd_cnt, 1);

    // Test 4: five back-to-back writes with the UART held busy.
    rx_log.delete();
    @(negedge clk); #1 force_busy = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      fill(1); valid_in = 1;
      if (i == 4) begin #3; check("t4_full", full, 1); check("t4_count", count, 4); end
    end
    @(negedge clk);
    valid_in = 0;
    #3;
    check("t4_overflow_pulse", overflow, 1);
    @(negedge clk); #3;
    check("t4_overflow_end", overflow, 0);
    check("t4_nothing_sent", rx_log.size(), 0);
    force_busy = 0;
    drain();
    check("t4_drained_bytes", rx_log.size(), 4 * FLEN);

    // Test 5: writes coinciding with frame_done at count=NS-1 and count=NS.
    for (int i = 0; i < 3; i++) write_one(1);
    wait_fd(to);
    check("t5a_timeout", to, 0);
    check("t5a_count_before", count, 3);
    fill(1); valid_in = 1;
    @(negedge clk);
    valid_in = 0;
    #3;
    check("t5a_count_after", count, 3);
    check("t5a_no_overflow", overflow, 0);
    write_one(1);
    #3;
    check("t5b_full", full, 1);
    wait_fd(to);
    check("t5b_timeout", to, 0);
    fill(1); valid_in = 1;
    @(negedge clk);
    valid_in = 0;
    #3;
    check("t5b_overflow", overflow, 1);
    check("t5b_count_after", count, 3);
    check("t5b_not_full", full, 0);
    drain();

    // Test 6: reset after five bytes of a frame.
    rx_log.delete();
    write_one(1);
    for (n = 0; n < 2000 && m_pos < 5; n++) @(negedge clk);
    check("t6_timeout", n >= 2000, 0);
    @(posedge clk); #2 rst_n = 0;
    #1;
    check("t6_rst_count", count, 0);
    check("t6_rst_full", full, 0);
    check("t6_rst_byte_out", byte_out, 0);
    check("t6_rst_valid_out", valid_out, 0);
    check("t6_rst_frame_done", frame_done, 0);
    check("t6_rst_overflow", overflow, 0);
    @(posedge clk); #2 rst_n = 1;
    sz = rx_log.size();
    repeat (40) @(negedge clk);
    check("t6_silent", rx_log.size(), sz);
    write_one(0);
    drain();
    check("t6_new_frame_len", rx_log.size(), sz + FLEN);
    if (rx_log.size() > sz) check("t6_new_hdr", rx_log[sz], 8'hA5);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      valid_in = ($urandom_range(0, 9) < 2);
      fill(1);
    end
    @(negedge clk);
    valid_in = 0;
    drain();

    check("dut2_finished", dut2_done, 1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tx_frame_buffer.md
Name: tx_frame_buffer

Overview:
Parametrised successor to the sorter's TX byte buffer. Queues up to NUM_SEQ sorted arrays of DEPTH words of WIDTH bits each, then sends each array as a framed byte stream to uart_tx over its start/busy handshake. Each frame is a header byte, a length byte, the payload bytes in a configurable byte order, and an optional checksum. The block sits between the bitonic sorter output and uart_tx.

Parameters:
WIDTH, 32, bits per word; must be a multiple of 8, range 8..64
DEPTH, 8, words per array; DEPTH*WIDTH/8 must be at most 255
NUM_SEQ, 4, FIFO capacity in arrays, range 1..16; need not be a power of 2
MSB_FIRST, 1, 1 = most significant byte of each word sent first; 0 = least significant byte first
HEADER, 8'hA5, first byte of every frame

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  array_in valid this cycle
array_in  in  WIDTH x DEPTH (unpacked [DEPTH-1:0])  sorted array; word 0 is sent first
full  out  1  FIFO holds NUM_SEQ arrays
count  out  $clog2(NUM_SEQ+1)  number of arrays stored, including the one being sent
tx_busy  in  1  busy from uart_tx
byte_out  out  8  byte to uart_tx data
valid_out  out  1  start pulse to uart_tx
frame_done  out  1  one-cycle pulse when the last byte of a frame has finished transmitting
overflow  out  1  one-cycle pulse when valid_in arrives while full

Behaviour:
- Reset (asynchronous, rst_n=0): FIFO emptied, pointers=0, FSM to IDLE; count=0, full=0, byte_out=0, valid_out=0, frame_done=0, overflow=0. Takes effect immediately, including mid-frame; a partly sent frame is discarded.
- Write: valid_in && !full stores all DEPTH words at wr_ptr on the clock edge. wr_ptr wraps from NUM_SEQ-1 to 0.
- Write when full: array dropped, storage unchanged, overflow=1 on the next cycle.
- full = (count==NUM_SEQ). Both full and count are registered.
- Pop: happens in the same cycle as frame_done; rd_ptr wraps from NUM_SEQ-1 to 0.
- Write and pop in the same cycle: both take effect and count is unchanged. A write while full is still dropped even if a pop occurs that cycle.
- Frame byte order: HEADER, then LEN = DEPTH*WIDTH/8 (8 bits), then payload. Payload is word 0 through word DEPTH-1; within each word, bytes go MSB to LSB if MSB_FIRST=1, otherwise LSB to MSB. Optional checksum byte is last.
- Byte counter width: $clog2(DEPTH*WIDTH/8+3).
- FSM states and transitions:
  - IDLE: if count>0, load byte index 0 and go to ISSUE.
  - ISSUE: if tx_busy=0, drive byte_out and set valid_out=1 for exactly one cycle, then go to WAIT_HI. If tx_busy=1, hold in ISSUE.
  - WAIT_HI: wait for tx_busy=1; go to WAIT_LO.
  - WAIT_LO: wait for tx_busy=0. If this was the last byte, pulse frame_done, pop, go to IDLE. Otherwise increment the byte index and go to ISSUE.
- byte_out holds its value from ISSUE until the next ISSUE.
- Latency: a write into an empty FIFO at edge N gives count=1 after N; IDLE to ISSUE at N+1; valid_out=1 in the cycle after N+1 if tx_busy=0.
- Back-to-back frames: after frame_done, IDLE re-enters ISSUE on the next edge if count>0. No idle gap other than the one IDLE cycle.
- valid_out is never asserted while tx_busy=1.

Optional Feature:
TX_FRAME_CHECKSUM_EN
- Defined: one extra byte follows the payload; it is the sum of all payload bytes modulo 256 (header and LEN excluded). Frame length is LEN+3 bytes.
- Undefined: no checksum logic is built; frame length is LEN+2 bytes.

Test Plan:
1. Single array, defaults, array_in[i]=i, paired with uart_tx and uart_rx -> receiver sees A5 20 00 00 00 00 00 00 00 01 ... 00 00 00 07. frame_done pulses once; count goes 1 then 0.
2. MSB_FIRST=0, WIDTH=16, DEPTH=2, words 16'h1234 and 16'hABCD -> bytes A5 04 34 12 CD AB.
3. TX_FRAME_CHECKSUM_EN defined, stimulus as in test 1 -> trailing byte 1C; frame is 35 bytes.
4. Five back-to-back writes with NUM_SEQ=4 while tx_busy is held at 1 -> full=1 after the 4th write; 5th write gives an overflow pulse. The 4 stored frames then drain in order with pointer wrap verified; the dropped array is never sent.
5. Write timed to the frame_done cycle while count=NUM_SEQ-1... and while count=NUM_SEQ -> count unchanged with the write accepted in the first case; write dropped with an overflow pulse in the second.
6. rst_n pulled low after 5 bytes of a frame -> outputs immediately take reset values; after release no further bytes are sent until a new valid_in, whose frame begins with A5.
